// File: rtl/writeback_stage.sv
// RV32 writeback stage: collects retiring instructions, aligns load data and drives the regfile write port.
// Optional macro WB_FWD_EN adds same-cycle forwarding outputs (fwd_valid/fwd_rd/fwd_data).
module writeback_stage #(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_reg_write,
    input  logic [4:0]       in_rd,
    input  logic [1:0]       in_result_src,
    input  logic [2:0]       in_funct3,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_pc_plus4,
    input  logic             dmem_rvalid,
    input  logic [31:0]      dmem_rdata,
    output logic             WE3,
    output logic [4:0]       A3,
    output logic [31:0]      WD3,
    output logic [CNT_W-1:0] retire_count,
    output logic             load_err
`ifdef WB_FWD_EN
    ,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [31:0]      fwd_data
`endif
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_LOAD = 2'd1;
    localparam logic [1:0] WRITE     = 2'd2;

    localparam int TW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

    logic [1:0]    state;
    logic [TW-1:0] wait_cnt;

    logic          cap_reg_write;
    logic [4:0]    cap_rd;
    logic [2:0]    cap_funct3;
    logic [1:0]    cap_off;

    logic          accept;
    logic          timeout_hit;
    logic          wr_fire;
    logic          wr_en;
    logic [4:0]    wr_rd;
    logic [31:0]   wr_data;
    logic [31:0]   load_data;

    function automatic logic [31:0] align_load(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  align_load = {{24{b[7]}}, b};
            3'b001:  align_load = {{16{h[15]}}, h};
            3'b100:  align_load = {24'b0, b};
            3'b101:  align_load = {16'b0, h};
            default: align_load = word;
        endcase
    endfunction

    assign in_ready  = (state == IDLE) || (state == WRITE);
    assign accept    = in_valid && in_ready;
    assign load_data = align_load(cap_funct3, cap_off, dmem_rdata);

    // A response arriving in the expiry cycle takes priority, so expiry requires !dmem_rvalid.
    always_comb begin
        timeout_hit = 1'b0;
        if (LOAD_TIMEOUT != 0) begin
            timeout_hit = (state == WAIT_LOAD) && !dmem_rvalid &&
                          (wait_cnt == TW'(LOAD_TIMEOUT - 1));
        end
    end

    // Non-loads write at the accept edge so WE3 is high the very next cycle; loads write when data lands.
    always_comb begin
        wr_fire = 1'b0;
        wr_en   = 1'b0;
        wr_rd   = in_rd;
        wr_data = in_alu_result;
        if (state == WAIT_LOAD) begin
            if (dmem_rvalid) begin
                wr_fire = 1'b1;
                wr_en   = cap_reg_write && (cap_rd != 5'd0);
                wr_rd   = cap_rd;
                wr_data = load_data;
            end
        end else if (accept && (in_result_src != 2'b01)) begin
            wr_fire = 1'b1;
            wr_en   = in_reg_write && (in_rd != 5'd0);
            wr_data = (in_result_src == 2'b10) ? in_pc_plus4 : in_alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            cap_reg_write <= 1'b0;
            cap_rd        <= 5'd0;
            cap_funct3    <= 3'd0;
            cap_off       <= 2'd0;
            WE3           <= 1'b0;
            A3            <= 5'd0;
            WD3           <= 32'd0;
            retire_count  <= '0;
            load_err      <= 1'b0;
        end else begin
            WE3 <= wr_en;
            if (wr_en) begin
                A3  <= wr_rd;
                WD3 <= wr_data;
            end
            if (wr_fire) begin
                retire_count <= retire_count + CNT_W'(1);
            end
            if (timeout_hit) begin
                load_err <= 1'b1;
            end
            if (accept) begin
                cap_reg_write <= in_reg_write;
                cap_rd        <= in_rd;
                cap_funct3    <= in_funct3;
                cap_off       <= in_alu_result[1:0];
            end
            case (state)
                IDLE, WRITE: begin
                    wait_cnt <= '0;
                    if (accept) begin
                        state <= (in_result_src == 2'b01) ? WAIT_LOAD : WRITE;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_LOAD: begin
                    if (dmem_rvalid) begin
                        state <= WRITE;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_FWD_EN
    // WE3 is only ever high while in WRITE, so the bypass mirrors the regfile write exactly.
    assign fwd_valid = (state == WRITE) && WE3;
    assign fwd_rd    = A3;
    assign fwd_data  = WD3;
`endif

endmodule
